// File: rtl/op_sequencer.sv
// op_sequencer: drives a 16-entry program into an external ALU, one instruction per cycle.
// The ALU's accumulator is cleared first and captured at the end of the run.
// The block records the first ALU error and, optionally, stops the program on it.
module op_sequencer #(
    parameter bit HALT_ON_ERR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_opcode,
    input  logic [31:0] wr_operand,
    input  logic [4:0]  prog_len,
    input  logic        start,
    input  logic [63:0] acc_in,
    input  logic [1:0]  err_in,
    output logic [3:0]  opcode,
    output logic [31:0] operand,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        halt_err,
    output logic [1:0]  err_code,
    output logic [3:0]  err_pc
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_CLEAR = 4'b1101;

    state_t      state_reg, state_next;
    logic [3:0]  pc_reg, pc_next;
    logic [4:0]  len_reg, len_next;
    logic [63:0] result_reg, result_next;
    logic        halt_err_reg, halt_err_next;
    logic [1:0]  err_code_reg, err_code_next;
    logic [3:0]  err_pc_reg, err_pc_next;
    logic        err_hit;

    // Program store is read combinationally from the registered pc, so it
    // maps to distributed RAM rather than a block RAM with a read register.
    logic [3:0]  mem_op  [16];
    logic [31:0] mem_opd [16];

    // Program load: only accepted while idle, and reset blocks the write.
    always_ff @(posedge clock) begin
        if (!reset && wr_en && (state_reg == IDLE)) begin
            mem_op[wr_addr]  <= wr_opcode;
            mem_opd[wr_addr] <= wr_operand;
        end
    end

    // Error qualification: only the three non-zero codes count; an unknown
    // bus makes the comparison non-true, so it falls through as "no error".
    always_comb begin
        err_hit = 1'b0;
        if ((err_in == 2'b01) || (err_in == 2'b10) || (err_in == 2'b11)) begin
            err_hit = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= 4'd0;
            len_reg      <= 5'd0;
            result_reg   <= 64'd0;
            halt_err_reg <= 1'b0;
            err_code_reg <= 2'b00;
            err_pc_reg   <= 4'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            len_reg      <= len_next;
            result_reg   <= result_next;
            halt_err_reg <= halt_err_next;
            err_code_reg <= err_code_next;
            err_pc_reg   <= err_pc_next;
        end
    end

    // Next-state logic and instruction bus.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        len_next      = len_reg;
        result_next   = result_reg;
        halt_err_next = halt_err_reg;
        err_code_next = err_code_reg;
        err_pc_next   = err_pc_reg;
        opcode        = OP_NOP;
        operand       = 32'd0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start && (prog_len != 5'd0)) begin
                    len_next      = (prog_len > 5'd16) ? 5'd16 : prog_len;
                    result_next   = 64'd0;
                    halt_err_next = 1'b0;
                    err_code_next = 2'b00;
                    err_pc_next   = 4'd0;
                    state_next    = CLEAR;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                opcode     = OP_CLEAR;
                pc_next    = 4'd0;
                state_next = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                opcode  = mem_op[pc_reg];
                operand = mem_opd[pc_reg];
                // First error of the run wins; later ones are not recorded.
                if (err_hit && !halt_err_reg) begin
                    halt_err_next = 1'b1;
                    err_code_next = err_in;
                    err_pc_next   = pc_reg;
                end
                if (err_hit && HALT_ON_ERR) begin
                    state_next = CAPTURE;
                end else if ({1'b0, pc_reg} == (len_reg - 5'd1)) begin
                    state_next = CAPTURE;
                end else begin
                    pc_next = pc_reg + 4'd1;
                end
            end
            CAPTURE: begin
                busy        = 1'b1;
                result_next = acc_in;
                state_next  = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result   = result_reg;
    assign halt_err = halt_err_reg;
    assign err_code = err_code_reg;
    assign err_pc   = err_pc_reg;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: two instances (halt on error / continue on error),
// each driving its own behavioural ALU, checked against a program-level model.
module tb_op_sequencer;

    logic        clock = 1'b0;
    logic        reset, wr_en, start;
    logic [3:0]  wr_addr, wr_opcode;
    logic [31:0] wr_operand;
    logic [4:0]  prog_len;

    logic [63:0] acc_h = 64'd0, acc_c = 64'd0;
    logic [1:0]  err_h, err_c;
    logic [3:0]  op_h, op_c, ep_h, ep_c;
    logic [31:0] opd_h, opd_c;
    logic        busy_h, busy_c, done_h, done_c, he_h, he_c;
    logic [63:0] res_h, res_c;
    logic [1:0]  ec_h, ec_c;

    logic [3:0]  prog_op [16];
    logic [31:0] prog_v  [16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    op_sequencer #(.HALT_ON_ERR(1'b1)) dut_h (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_opcode(wr_opcode), .wr_operand(wr_operand), .prog_len(prog_len),
        .start(start), .acc_in(acc_h), .err_in(err_h), .opcode(op_h),
        .operand(opd_h), .busy(busy_h), .done(done_h), .result(res_h),
        .halt_err(he_h), .err_code(ec_h), .err_pc(ep_h));

    op_sequencer #(.HALT_ON_ERR(1'b0)) dut_c (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_opcode(wr_opcode), .wr_operand(wr_operand), .prog_len(prog_len),
        .start(start), .acc_in(acc_c), .err_in(err_c), .opcode(op_c),
        .operand(opd_c), .busy(busy_c), .done(done_c), .result(res_c),
        .halt_err(he_c), .err_code(ec_c), .err_pc(ep_c));

    // ALU semantics: 1101 clear, 0001 add, 0010 sub, 0011 mul, 0100 div, 0101 mod.
    function automatic logic [63:0] alu_step(input logic [63:0] a, input logic [3:0] op,
                                             input logic [31:0] v);
        case (op)
            4'b1101: return 64'd0;
            4'b0001: return a + 64'(v);
            4'b0010: return a - 64'(v);
            4'b0011: return a * 64'(v);
            4'b0100: return (v == 32'd0) ? a : a / 64'(v);
            4'b0101: return (v == 32'd0) ? a : a % 64'(v);
            default: return a;
        endcase
    endfunction

    // Error codes: 01 add overflow, 11 sub underflow, 10 divide by zero.
    function automatic logic [1:0] alu_err(input logic [63:0] a, input logic [3:0] op,
                                           input logic [31:0] v);
        case (op)
            4'b0001: return ((a + 64'(v)) < a) ? 2'b01 : 2'b00;
            4'b0010: return (64'(v) > a) ? 2'b11 : 2'b00;
            4'b0100, 4'b0101: return (v == 32'd0) ? 2'b10 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clock) begin
        acc_h <= alu_step(acc_h, op_h, opd_h);
        acc_c <= alu_step(acc_c, op_c, opd_c);
    end

    always_comb begin
        err_h = alu_err(acc_h, op_h, opd_h);
        err_c = alu_err(acc_c, op_c, opd_c);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program-level model: run the stored program on an accumulator.
    task automatic model(input bit halt, input int len, output logic [63:0] r,
                         output int issued, output logic he, output logic [1:0] ec,
                         output logic [3:0] ep);
        logic [63:0] a;
        logic [1:0]  e;
        a = 64'd0; issued = 0; he = 1'b0; ec = 2'b00; ep = 4'd0;
        for (int i = 0; i < len; i++) begin
            e = alu_err(a, prog_op[i], prog_v[i]);
            if (e != 2'b00 && !he) begin
                he = 1'b1; ec = e; ep = 4'(i);
            end
            a = alu_step(a, prog_op[i], prog_v[i]);
            issued++;
            if (e != 2'b00 && halt) break;
        end
        r = a;
    endtask

    function automatic logic [3:0] exp_op(input int c, input int iss);
        if (c == 0) return 4'b1101;
        if (c <= iss) return prog_op[c-1];
        return 4'b0000;
    endfunction

    function automatic logic [31:0] exp_opd(input int c, input int iss);
        if (c >= 1 && c <= iss) return prog_v[c-1];
        return 32'd0;
    endfunction

    task automatic write_word(input int a, input logic [3:0] op, input logic [31:0] v);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 4'(a); wr_opcode = op; wr_operand = v;
        prog_op[a] = op; prog_v[a] = v;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Start a run and check both instances cycle by cycle, then their final state.
    task automatic run_prog(input string tag, input int plen, input bit mid_pulse,
                            input bit wr_same, input logic [3:0] wa,
                            input logic [3:0] wop, input logic [31:0] wv);
        int len, iss_h, iss_c;
        logic [63:0] r_h, r_c;
        logic he_m_h, he_m_c;
        logic [1:0] ec_m_h, ec_m_c;
        logic [3:0] ep_m_h, ep_m_c;
        if (wr_same) begin
            prog_op[wa] = wop; prog_v[wa] = wv;
        end
        len = (plen > 16) ? 16 : plen;
        model(1'b1, len, r_h, iss_h, he_m_h, ec_m_h, ep_m_h);
        model(1'b0, len, r_c, iss_c, he_m_c, ec_m_c, ep_m_c);
        @(negedge clock);
        start = 1'b1; prog_len = 5'(plen);
        if (wr_same) begin
            wr_en = 1'b1; wr_addr = wa; wr_opcode = wop; wr_operand = wv;
        end
        @(negedge clock);
        start = 1'b0; wr_en = 1'b0;
        for (int c = 0; c <= iss_c + 3; c++) begin
            if (c > 0) @(negedge clock);
            check({tag, " op_h"}, 64'(op_h), 64'(exp_op(c, iss_h)));
            check({tag, " op_c"}, 64'(op_c), 64'(exp_op(c, iss_c)));
            if (c <= iss_h + 1) check({tag, " opd_h"}, 64'(opd_h), 64'(exp_opd(c, iss_h)));
            if (c <= iss_c + 1) check({tag, " opd_c"}, 64'(opd_c), 64'(exp_opd(c, iss_c)));
            check({tag, " busy_h"}, 64'(busy_h), 64'(c <= iss_h + 1));
            check({tag, " busy_c"}, 64'(busy_c), 64'(c <= iss_c + 1));
            check({tag, " done_h"}, 64'(done_h), 64'(c == iss_h + 2));
            check({tag, " done_c"}, 64'(done_c), 64'(c == iss_c + 2));
            if (mid_pulse) begin
                if (c == 2 || c == iss_h + 2) begin
                    start = 1'b1; prog_len = 5'd3;
                    wr_en = 1'b1; wr_addr = 4'd0; wr_opcode = 4'hF; wr_operand = 32'hDEAD;
                end else begin
                    start = 1'b0; wr_en = 1'b0;
                end
            end
        end
        start = 1'b0; wr_en = 1'b0;
        @(negedge clock);
        check({tag, " res_h"}, res_h, r_h);
        check({tag, " res_c"}, res_c, r_c);
        check({tag, " he_h"}, 64'(he_h), 64'(he_m_h));
        check({tag, " he_c"}, 64'(he_c), 64'(he_m_c));
        check({tag, " ec_h"}, 64'(ec_h), 64'(ec_m_h));
        check({tag, " ec_c"}, 64'(ec_c), 64'(ec_m_c));
        check({tag, " ep_h"}, 64'(ep_h), 64'(ep_m_h));
        check({tag, " ep_c"}, 64'(ep_c), 64'(ep_m_c));
        $display("run %s len=%0d issued_h=%0d issued_c=%0d res_h=%0d res_c=%0d",
                 tag, len, iss_h, iss_c, res_h, res_c);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = 4'd0;
        wr_opcode = 4'd0; wr_operand = 32'd0; prog_len = 5'd0;
        for (int i = 0; i < 16; i++) begin
            prog_op[i] = 4'd0; prog_v[i] = 32'd0;
        end
        repeat (3) @(negedge clock);
        check("rst busy", 64'(busy_h), 64'd0);
        check("rst done", 64'(done_h), 64'd0);
        check("rst op", 64'(op_h), 64'd0);
        check("rst opd", 64'(opd_h), 64'd0);
        check("rst res", res_h, 64'd0);
        check("rst he", 64'(he_h), 64'd0);
        check("rst ec", 64'(ec_h), 64'd0);
        check("rst ep", 64'(ep_h), 64'd0);
        reset = 1'b0;
        // Clear every slot so later partial programs start from known contents.
        for (int i = 0; i < 16; i++) write_word(i, 4'b0000, 32'd0);

        // Add sequence.
        write_word(0, 4'b0001, 32'd3); write_word(1, 4'b0001, 32'd4);
        write_word(2, 4'b0001, 32'd5);
        run_prog("add3", 3, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        check("add3 literal", res_h, 64'd12);

        // Mul/div then mod.
        write_word(0, 4'b0001, 32'd2); write_word(1, 4'b0011, 32'd5);
        write_word(2, 4'b0011, 32'd314); write_word(3, 4'b0100, 32'd100);
        run_prog("muldiv", 4, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        check("muldiv literal", res_h, 64'd31);
        write_word(0, 4'b0001, 32'd3140); write_word(1, 4'b0101, 32'd100);
        run_prog("mod", 2, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        check("mod literal", res_h, 64'd40);

        // Divide by zero at pc1.
        write_word(0, 4'b0001, 32'd7); write_word(1, 4'b0100, 32'd0);
        write_word(2, 4'b0001, 32'd1);
        run_prog("divzero", 3, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        check("divzero ec literal", 64'(ec_h), 64'd2);
        check("divzero ep literal", 64'(ep_c), 64'd1);
        check("divzero res_c literal", res_c, 64'd8);

        // Reset in RUN at pc1, then rerun the retained program.
        @(negedge clock); start = 1'b1; prog_len = 5'd3;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst pc1 op", 64'(op_h), 64'(prog_op[1]));
        reset = 1'b1;
        @(negedge clock);
        check("midrst busy", 64'(busy_h), 64'd0);
        check("midrst op", 64'(op_c), 64'd0);
        check("midrst res", res_h, 64'd0);
        check("midrst he", 64'(he_h), 64'd0);
        check("midrst done", 64'(done_c), 64'd0);
        reset = 1'b0;
        run_prog("afterrst", 3, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);

        // Start and write while busy / in DONE are ignored; rerun confirms memory.
        run_prog("busyign", 3, 1'b1, 1'b0, 4'd0, 4'd0, 32'd0);
        run_prog("busyrerun", 3, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);

        // Zero length start is ignored.
        @(negedge clock); start = 1'b1; prog_len = 5'd0;
        @(negedge clock); start = 1'b0;
        check("len0 busy", 64'(busy_h), 64'd0);
        check("len0 op", 64'(op_h), 64'd0);
        check("len0 res held", res_h, 64'd7);

        // Write and start in the same cycle use the new word.
        run_prog("wrsame", 3, 1'b0, 1'b1, 4'd1, 4'b0001, 32'd10);
        check("wrsame literal", res_c, 64'd18);

        // Over-long length clamps to 16 instructions.
        for (int i = 0; i < 16; i++) write_word(i, 4'b0001, 32'(i + 1));
        run_prog("len20", 20, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        check("len20 literal", res_h, 64'd136);

        // Random programs.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) begin
                write_word(i, 4'($urandom_range(1, 5)), 32'($urandom_range(0, 20)));
            end
            run_prog($sformatf("rand%0d", t), int'($urandom_range(1, 20)),
                     1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter: HALT_ON_ERR, default 1, meaning 1 = stop the program on the first reported ALU error, 0 = record the error and continue.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  program-memory write strobe.
REQ-005 wr_addr  input  4  program-memory write address, 0-15.
REQ-006 wr_opcode  input  4  opcode to store.
REQ-007 wr_operand  input  32  operand to store.
REQ-008 prog_len  input  5  number of instructions to run, sampled with start.
REQ-009 start  input  1  run request.
REQ-010 acc_in  input  64  ALU result bus (breadboard output1).
REQ-011 err_in  input  2  ALU error bus (breadboard error).
REQ-012 opcode  output  4  drives the breadboard opcode input.
REQ-013 operand  output  32  drives the breadboard input1 input.
REQ-014 busy  output  1  high while a program is executing.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 result  output  64  captured final accumulator value.
REQ-017 halt_err  output  1  an error was recorded in the last run.
REQ-018 err_code  output  2  first error value recorded.
REQ-019 err_pc  output  4  instruction index of the first error.

Function
REQ-020 The program memory SHALL hold 16 entries of {opcode[3:0], operand[31:0]}; it is written at the clock edge when wr_en=1 in IDLE, and writes in any other state are ignored.
REQ-021 The FSM SHALL have the states IDLE, CLEAR, RUN, CAPTURE and DONE.
REQ-022 IDLE: opcode=0000 and operand=0; start=1 with prog_len>0 SHALL latch len=min(prog_len,16), clear result, halt_err, err_code and err_pc, and go to CLEAR; start with prog_len=0 SHALL be ignored.
REQ-023 CLEAR (one cycle): opcode=1101 and operand=0, err_in ignored; pc<=0 and the FSM goes to RUN.
REQ-024 RUN: opcode and operand SHALL equal mem[pc] combinationally from the registered pc; one instruction is issued per cycle.
REQ-025 At each RUN edge, an error SHALL be recorded only when err_in is exactly 01, 10 or 11; an err_in of 00 or any value containing x/z SHALL count as no error.
REQ-026 On the first recorded error, the block SHALL set halt_err=1, err_code=err_in and err_pc=pc; later errors in the same run SHALL NOT overwrite these.
REQ-027 With HALT_ON_ERR=1, a recorded error SHALL send the FSM to CAPTURE without issuing further instructions.
REQ-028 Otherwise, pc==len-1 SHALL send the FSM to CAPTURE, and any other pc SHALL advance as pc<=pc+1.
REQ-029 CAPTURE (one cycle): opcode=0000 and operand=0; result<=acc_in at the edge; the FSM then goes to DONE.
REQ-030 DONE (one cycle): done=1 and opcode=0000; the FSM then goes to IDLE.
REQ-031 busy SHALL be 1 in CLEAR, RUN and CAPTURE, and 0 in IDLE and DONE.
REQ-032 start while busy=1 or in DONE SHALL be ignored.
REQ-033 Latency: done SHALL go high exactly len+2 rising edges after the edge that accepted start (fewer if halted early).
REQ-034 wr_en and start in the same IDLE cycle SHALL both take effect, and the run SHALL use the newly written data.
REQ-035 result, err_code and err_pc SHALL hold their values until the next accepted start or reset.

Reset
REQ-036 reset SHALL force IDLE from any state, including mid-RUN, with pc=0, opcode=0000, operand=0, busy=0, done=0, result=0, halt_err=0, err_code=00 and err_pc=0.
REQ-037 Reset SHALL NOT clear program memory, and reset SHALL take priority over start and wr_en.

Verification
REQ-038 Program {0001/3, 0001/4, 0001/5}, len 3, start -> opcode sequence 1101,0001,0001,0001,0000; done 5 edges after start; result=12; halt_err=0.
REQ-039 Program {0001/2, 0011/5, 0011/314, 0100/100}, len 4, start -> result=31; then program {0001/3140, 0101/100} -> result=40.
REQ-040 Program {0001/7, 0100/0, 0001/1}, err_in=10 during pc1 -> halt_err=1, err_code=10, err_pc=1; opcode 0001 for pc2 is never driven; done 4 edges after start.
REQ-041 Same program with HALT_ON_ERR=0 -> all 3 instructions issued; err_pc=1; done 5 edges after start.
REQ-042 reset asserted during RUN at pc=1 -> next cycle busy=0, opcode=0000, result=0; a subsequent start reruns the retained program with an identical result.
REQ-043 start pulsed while busy, wr_en while busy, and prog_len=0 -> all ignored (state and memory unchanged); prog_len=20 -> runs 16 instructions.
